bcd_display_scan: RTL



---
 rtl/bcd_display_scan_if.sv | 30 +++
 rtl/bcd_display_scan.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/bcd_display_scan_if.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_display_scan_if
//  Description : Bundles the adder-facing capture signals and the display pins
//                of the two-digit BCD scan driver.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bcd_display_scan_if;
  logic       load;
  logic [3:0] bcd1;
  logic [3:0] bcd0;
  logic       err;
  logic [6:0] seg;
  logic [1:0] dig_en;
  logic       frame;
  logic       err_out;

  // Source of the adder results; sink of the display pins
  modport master (
    output load, bcd1, bcd0, err,
    input  seg, dig_en, frame, err_out
  );

  // The scan driver itself
  modport slave (
    input  load, bcd1, bcd0, err,
    output seg, dig_en, frame, err_out
  );
endinterface
`default_nettype wire

// File: rtl/bcd_display_scan.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_display_scan
//  Description : Captures a two-digit BCD sum plus error flag and drives a
//                time-multiplexed two-digit seven-segment display with
//                leading-zero blanking and a blinking "E E" error pattern.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_display_scan #(
  parameter int PRESCALE       = 4,
  parameter int BLINK_DIV      = 8,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  bcd_display_scan_if.slave  bus
);

  localparam int CW = (PRESCALE  > 1) ? $clog2(PRESCALE)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CW-1:0] c_cnt_last = CW'(PRESCALE - 1);
  localparam logic [BW-1:0] c_blk_last = BW'(BLINK_DIV - 1);
  localparam logic [6:0]    c_seg_e    = 7'b1111001;
  localparam logic [6:0]    c_seg_inv  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [1:0]    c_dig_inv  = SEG_ACTIVE_LOW ? 2'b11 : 2'b00;

  typedef enum logic [0:0] {
    S_ONES = 1'b0,
    S_TENS = 1'b1
  } state_t;

  // Held copy of the adder result
  logic [3:0]    held1_q, held0_q;
  logic          held_err_q;
  // Scan timing
  logic [CW-1:0] cnt_q, cnt_d;
  state_t        state_q, state_d;
  // Blink timing
  logic [BW-1:0] blk_q, blk_d;
  logic          phase_q, phase_d;
  // Output registers (already polarity-adjusted)
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    dig_q, dig_d;
  logic          frame_q;
  logic          err_out_q;

  logic          tick_w;
  logic          frame_ev_w;
  logic          err_eff_w;

  function automatic logic [6:0] f_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // Next-state logic for prescaler, scan FSM, blink and the display image
  always_comb begin
    tick_w     = (cnt_q == c_cnt_last);
    cnt_d      = tick_w ? '0 : cnt_q + CW'(1);
    state_d    = state_q;
    if (tick_w) begin
      state_d = (state_q == S_ONES) ? S_TENS : S_ONES;
    end
    frame_ev_w = tick_w && (state_q == S_TENS);

    // A load restarts the blink so a fresh error always begins with "E E"
    blk_d   = blk_q;
    phase_d = phase_q;
    if (bus.load) begin
      blk_d   = '0;
      phase_d = 1'b0;
    end else if (frame_ev_w) begin
      if (blk_q == c_blk_last) begin
        blk_d   = '0;
        phase_d = ~phase_q;
      end else begin
        blk_d = blk_q + BW'(1);
      end
    end

    // Non-BCD digits are treated as errors as well as the adder's own flag
    err_eff_w = held_err_q || (held1_q > 4'd9) || (held0_q > 4'd9);

    // Image is chosen for the slot that becomes active on this edge
    if (err_eff_w) begin
      seg_d = phase_q ? 7'b0000000 : c_seg_e;
    end else if (state_d == S_ONES) begin
      seg_d = f_decode(held0_q);
    end else begin
      seg_d = (held1_q == 4'd0) ? 7'b0000000 : f_decode(held1_q);
    end
    dig_d = (state_d == S_ONES) ? 2'b01 : 2'b10;
  end

  // Scan FSM with registered display outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      state_q   <= S_ONES;
      seg_q     <= c_seg_inv;
      dig_q     <= c_dig_inv;
      frame_q   <= 1'b0;
      err_out_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      seg_q     <= seg_d ^ c_seg_inv;
      dig_q     <= dig_d ^ c_dig_inv;
      frame_q   <= frame_ev_w;
      err_out_q <= err_eff_w;
    end
  end

  // Capture of adder result and blink phase tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held1_q    <= 4'd0;
      held0_q    <= 4'd0;
      held_err_q <= 1'b0;
      blk_q      <= '0;
      phase_q    <= 1'b0;
    end else begin
      if (bus.load) begin
        held1_q    <= bus.bcd1;
        held0_q    <= bus.bcd0;
        held_err_q <= bus.err;
      end
      blk_q   <= blk_d;
      phase_q <= phase_d;
    end
  end

  assign bus.seg     = seg_q;
  assign bus.dig_en  = dig_q;
  assign bus.frame   = frame_q;
  assign bus.err_out = err_out_q;

endmodule
`default_nettype wire
